// File: rtl/serial_word_rx.sv
// Serial-in/parallel-out receiver: assembles SOF-framed bits into WIDTH-bit words.
// Latency: last bit to out_valid is 1 cycle; a full, unconsumed output stage drops the new word and flags overrun.
module serial_word_rx #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sin_valid,
  input  logic             sin_data,
  input  logic             sin_sof,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             sof_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, base, shifted, data_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             acc, done, sof_set, ovr_set;
  logic             valid_nxt, overrun_nxt, sof_err_nxt;

  assign acc  = en & sin_valid;
  assign busy = (state == SHIFT);

  // An SOF bit starts from a clean register so no stale bits survive a resync.
  always_comb begin
    base = sin_sof ? '0 : shreg;
    if (MSB_FIRST) shifted = {base[WIDTH-2:0], sin_data};
    else           shifted = {sin_data, base[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    done      = 1'b0;
    sof_set   = 1'b0;
    case (state)
      IDLE: begin
        if (acc && sin_sof) begin
          shreg_nxt = shifted;
          cnt_nxt   = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (acc) begin
          shreg_nxt = shifted;
          if (sin_sof) begin
            sof_set = 1'b1;
            cnt_nxt = CW'(1);
          end else if (cnt == CW'(WIDTH - 1)) begin
            done      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_nxt  = data_out;
    valid_nxt = out_valid;
    ovr_set   = 1'b0;
    if (out_valid && out_ready) valid_nxt = 1'b0;
    if (done) begin
      if (!out_valid || out_ready) begin
        data_nxt  = shifted;
        valid_nxt = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    // Error set takes priority over a simultaneous clear.
    overrun_nxt = ovr_set | (overrun & ~clr_err);
    sof_err_nxt = sof_set | (sof_err & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      data_out  <= data_nxt;
      out_valid <= valid_nxt;
      overrun   <= overrun_nxt;
      sof_err   <= sof_err_nxt;
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: three instances (8-bit MSB-first, 8-bit LSB-first, 32-bit MSB-first) on shared stimulus,
// compared against a bit-placement reference model.
module tb_serial_word_rx;

  logic clk = 1'b0;
  logic rst, en, sin_valid, sin_data, sin_sof, out_ready, clr_err;

  logic [7:0]  d_a, d_b;
  logic [31:0] d_c;
  logic v_a, o_a, s_a, b_a;
  logic v_b, o_b, s_b, b_b;
  logic v_c, o_c, s_c, b_c;

  int total = 0;
  int bad   = 0;
  int n_a, n_b;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en), .sin_valid(sin_valid), .sin_data(sin_data), .sin_sof(sin_sof),
    .out_ready(out_ready), .clr_err(clr_err), .data_out(d_a), .out_valid(v_a), .overrun(o_a),
    .sof_err(s_a), .busy(b_a));

  serial_word_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .sin_valid(sin_valid), .sin_data(sin_data), .sin_sof(sin_sof),
    .out_ready(out_ready), .clr_err(clr_err), .data_out(d_b), .out_valid(v_b), .overrun(o_b),
    .sof_err(s_b), .busy(b_b));

  serial_word_rx #(.WIDTH(32), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .sin_valid(sin_valid), .sin_data(sin_data), .sin_sof(sin_sof),
    .out_ready(out_ready), .clr_err(clr_err), .data_out(d_c), .out_valid(v_c), .overrun(o_c),
    .sof_err(s_c), .busy(b_c));

  // Handshake counters for the 8-bit instances.
  always @(posedge clk) begin
    if (rst) begin
      n_a <= 0;
      n_b <= 0;
    end else begin
      if (v_a && out_ready) n_a <= n_a + 1;
      if (v_b && out_ready) n_b <= n_b + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the i-th received bit lands at word[n-1-i] (MSB first) or word[i] (LSB first).
  function automatic logic [31:0] model_word(input int n, input logic [31:0] seq, input bit msb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) begin
      if (msb) r[n-1-i] = seq[i];
      else     r[i]     = seq[i];
    end
    return r;
  endfunction

  // Transmission order for a named word: seq[i] is the i-th bit on the wire.
  function automatic logic [31:0] seq_of(input logic [31:0] word, input int n, input bit msb);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s[i] = msb ? word[n-1-i] : word[i];
    return s;
  endfunction

  // Sends n bits with SOF on the first; optional random idle gaps and one 10-cycle en=0 pause mid-word.
  task automatic send_seq(input int n, input logic [31:0] seq, input bit gaps, input bit pause);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          sin_valid = 1'b0;
          sin_data  = 1'($urandom);
          sin_sof   = 1'($urandom);
          tick();
        end
      end
      if (pause && i == n / 2) begin
        en = 1'b0;
        repeat (10) begin
          sin_valid = 1'b1;
          sin_data  = 1'($urandom);
          sin_sof   = 1'($urandom);
          tick();
        end
        en = 1'b1;
      end
      sin_valid = 1'b1;
      sin_data  = seq[i];
      sin_sof   = (i == 0);
      tick();
      sin_valid = 1'b0;
      sin_sof   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;

    rst = 1'b1; en = 1'b1; sin_valid = 1'b0; sin_data = 1'b0; sin_sof = 1'b0;
    out_ready = 1'b1; clr_err = 1'b0;
    tick();
    tick();

    chk("rst_data_a", d_a, 0);
    chk("rst_valid_a", v_a, 0);
    chk("rst_ovr_a", o_a, 0);
    chk("rst_sof_a", s_a, 0);
    chk("rst_busy_a", b_a, 0);
    chk("rst_valid_b", v_b, 0);
    chk("rst_data_c", d_c, 0);
    chk("rst_busy_c", b_c, 0);
    rst = 1'b0;
    tick();

    // Basic frame 1,0,1,0,0,1,0,1
    seq = 32'hA5;
    send_seq(7, seq, 1'b0, 1'b0);
    chk("basic_busy_a", b_a, 1);
    chk("basic_early_valid_a", v_a, 0);
    sin_valid = 1'b1; sin_data = seq[7]; tick(); sin_valid = 1'b0;
    chk("basic_valid_a", v_a, 1);
    chk("basic_data_a", d_a, 32'hA5);
    chk("basic_model_a", d_a, model_word(8, seq, 1'b1));
    chk("basic_data_b", d_b, 32'hA5);
    chk("basic_idle_a", b_a, 0);
    tick();
    chk("basic_pulse_a", v_a, 0);
    chk("basic_hold_a", d_a, 32'hA5);

    // LSB-first frame 1,1,0,0,0,0,0,0
    do_reset();
    seq = 32'h03;
    send_seq(8, seq, 1'b0, 1'b0);
    chk("lsb_data_b", d_b, 32'h03);
    chk("lsb_valid_b", v_b, 1);
    chk("lsb_model_a", d_a, model_word(8, seq, 1'b1));

    // 32-bit with gaps and en pause
    do_reset();
    seq = seq_of(32'hDEADBEEF, 32, 1'b1);
    send_seq(32, seq, 1'b1, 1'b1);
    chk("gap_data_c", d_c, 32'hDEADBEEF);
    chk("gap_valid_c", v_c, 1);
    chk("gap_ovr_c", o_c, 0);
    chk("gap_sof_c", s_c, 0);

    // Overrun
    do_reset();
    out_ready = 1'b0;
    send_seq(8, seq_of(32'h11, 8, 1'b1), 1'b0, 1'b0);
    chk("ovr_first_data_a", d_a, 32'h11);
    chk("ovr_first_flag_a", o_a, 0);
    send_seq(8, seq_of(32'h22, 8, 1'b1), 1'b1, 1'b0);
    chk("ovr_data_a", d_a, 32'h11);
    chk("ovr_flag_a", o_a, 1);
    chk("ovr_valid_a", v_a, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovr_clear_a", o_a, 0);
    out_ready = 1'b1; tick();
    chk("ovr_drain_valid_a", v_a, 0);
    chk("ovr_drain_data_a", d_a, 32'h11);

    // Resync: 3 bits then a fresh SOF word
    do_reset();
    send_seq(3, 32'($urandom), 1'b0, 1'b0);
    chk("rsync_pre_sof_a", s_a, 0);
    chk("rsync_busy_a", b_a, 1);
    send_seq(8, seq_of(32'h3C, 8, 1'b1), 1'b0, 1'b0);
    chk("rsync_sof_a", s_a, 1);
    chk("rsync_data_a", d_a, 32'h3C);
    tick();
    chk("rsync_events_a", n_a, 1);
    chk("rsync_after_valid_a", v_a, 0);

    // Reset mid-word
    do_reset();
    send_seq(5, 32'($urandom), 1'b0, 1'b0);
    rst = 1'b1; tick();
    chk("mrst_valid_a", v_a, 0);
    chk("mrst_busy_a", b_a, 0);
    rst = 1'b0;
    seq = seq_of(32'hF0, 8, 1'b1);
    send_seq(7, seq, 1'b0, 1'b0);
    chk("mrst_pre_valid_a", v_a, 0);
    sin_valid = 1'b1; sin_data = seq[7]; tick(); sin_valid = 1'b0;
    chk("mrst_data_a", d_a, 32'hF0);
    chk("mrst_valid_done_a", v_a, 1);

    // Random frames, back-to-back, checked on both bit orders
    do_reset();
    for (int k = 0; k < 6; k++) begin
      seq = {24'h0, 8'($urandom)};
      send_seq(8, seq, k[0], 1'b0);
      chk("rand_data_a", d_a, model_word(8, seq, 1'b1));
      chk("rand_data_b", d_b, model_word(8, seq, 1'b0));
    end
    chk("rand_sof_a", s_a, 0);
    chk("rand_ovr_b", o_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
